mem_wr_burst_arbiter: RTL

Two-channel round-robin arbiter that merges the burst-write request ports of two frame buffer write controllers (ch0, ch1) onto the single burst-write port of the DDR memory controller. It latches the winning channel's length and address, then drives the downstream request. It routes the data-request strobe, write data and burst-finish between the controller and the granted channel. It sits in the mem_clk domain, directly downstream of the vin frame buffer write controllers.

---
 rtl/mem_wr_arb_pkg.sv | 16 +
 rtl/burst_rr_select.sv | 20 ++
 rtl/mem_wr_burst_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_wr_arb_pkg.sv
// rtl/mem_wr_arb_pkg.sv - shared constants and state encoding for the memory write burst arbiter
package mem_wr_arb_pkg;

  localparam int DEF_LEN_BITS  = 10;
  localparam int DEF_ADDR_BITS = 24;
  localparam int BURST_LEN     = 128;

  typedef enum logic [2:0] {
    ST_ARB  = 3'd0,
    ST_REQ  = 3'd1,
    ST_DATA = 3'd2,
    ST_FIN  = 3'd3,
    ST_ZFIN = 3'd4
  } arb_state_t;

endpackage

// File: rtl/burst_rr_select.sv
// rtl/burst_rr_select.sv - two-input round-robin picker
module burst_rr_select (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_winner
);

  // With both requesting, the channel that did not win last time goes next
  always_comb begin
    o_valid  = |i_req;
    o_winner = 1'b0;
    if (i_req == 2'b11) begin
      o_winner = ~i_last_grant;
    end else begin
      o_winner = i_req[1];
    end
  end

endmodule

// File: rtl/mem_wr_burst_arbiter.sv
// rtl/mem_wr_burst_arbiter.sv - two-channel round-robin merge of burst-write ports onto the DDR controller
module mem_wr_burst_arbiter
  import mem_wr_arb_pkg::*;
#(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int LEN_BITS      = DEF_LEN_BITS
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     ch0_wr_burst_req,
  input  logic [LEN_BITS-1:0]      ch0_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     ch0_wr_burst_addr,
  output logic                     ch0_wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] ch0_wr_burst_data,
  output logic                     ch0_burst_finish,
  input  logic                     ch1_wr_burst_req,
  input  logic [LEN_BITS-1:0]      ch1_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     ch1_wr_burst_addr,
  output logic                     ch1_wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] ch1_wr_burst_data,
  output logic                     ch1_burst_finish,
  output logic                     wr_burst_req,
  output logic [LEN_BITS-1:0]      wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     grant_ch,
  output logic                     busy,
  output logic                     len_err
);

  arb_state_t            r_state;
  logic                  r_req;
  logic [LEN_BITS-1:0]   r_len;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  r_grant_ch;
  logic                  r_last_grant;
  logic                  r_len_err;
  logic [LEN_BITS:0]     r_beat_cnt;

  logic                  w_sel_valid;
  logic                  w_sel_winner;
  logic [LEN_BITS-1:0]   w_sel_len;
  logic [ADDR_BITS-1:0]  w_sel_addr;
  logic [LEN_BITS:0]     w_beat_inc;
  logic [LEN_BITS:0]     w_beat_next;
  logic                  w_len_mismatch;
  logic                  w_route;

  burst_rr_select u_rr_select (
    .i_req        ({ch1_wr_burst_req, ch0_wr_burst_req}),
    .i_last_grant (r_last_grant),
    .o_valid      (w_sel_valid),
    .o_winner     (w_sel_winner)
  );

  // Winner's request fields, and the beat count including this cycle's strobe
  always_comb begin
    w_sel_len      = w_sel_winner ? ch1_wr_burst_len  : ch0_wr_burst_len;
    w_sel_addr     = w_sel_winner ? ch1_wr_burst_addr : ch0_wr_burst_addr;
    w_beat_inc     = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + 1'b1;
    w_beat_next    = wr_burst_data_req ? w_beat_inc : r_beat_cnt;
    w_len_mismatch = (w_beat_next != {1'b0, r_len});
    w_route        = (r_state == ST_REQ) || (r_state == ST_DATA);
  end

  // Burst FSM; len_err is registered on the transition into FIN so it is high during FIN
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_state      <= ST_ARB;
      r_req        <= 1'b0;
      r_len        <= '0;
      r_addr       <= '0;
      r_grant_ch   <= 1'b0;
      r_last_grant <= 1'b1;
      r_len_err    <= 1'b0;
      r_beat_cnt   <= '0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ST_ARB: begin
          if (w_sel_valid) begin
            r_grant_ch <= w_sel_winner;
            r_len      <= w_sel_len;
            r_addr     <= w_sel_addr;
            if (w_sel_len != '0) begin
              r_state    <= ST_REQ;
              r_req      <= 1'b1;
              r_beat_cnt <= '0;
            end else begin
              r_state <= ST_ZFIN;
            end
          end
        end
        ST_REQ: begin
          r_beat_cnt <= w_beat_next;
          if (wr_burst_finish) begin
            r_state   <= ST_FIN;
            r_req     <= 1'b0;
            r_len_err <= w_len_mismatch;
          end else if (wr_burst_data_req) begin
            r_state <= ST_DATA;
            r_req   <= 1'b0;
          end
        end
        ST_DATA: begin
          r_beat_cnt <= w_beat_next;
          if (wr_burst_finish) begin
            r_state   <= ST_FIN;
            r_len_err <= w_len_mismatch;
          end
        end
        ST_FIN, ST_ZFIN: begin
          r_last_grant <= r_grant_ch;
          r_state      <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  // Zero-latency routing of controller strobes and data to the granted channel only
  always_comb begin
    ch0_wr_burst_data_req = w_route && !r_grant_ch && wr_burst_data_req;
    ch1_wr_burst_data_req = w_route &&  r_grant_ch && wr_burst_data_req;
    ch0_burst_finish      = !r_grant_ch &&
                            ((w_route && wr_burst_finish) || (r_state == ST_ZFIN));
    ch1_burst_finish      =  r_grant_ch &&
                            ((w_route && wr_burst_finish) || (r_state == ST_ZFIN));
    wr_burst_data         = (w_route && r_grant_ch) ? ch1_wr_burst_data : ch0_wr_burst_data;
  end

  assign wr_burst_req  = r_req;
  assign wr_burst_len  = r_len;
  assign wr_burst_addr = r_addr;
  assign grant_ch      = r_grant_ch;
  assign len_err       = r_len_err;
  assign busy          = (r_state == ST_REQ) || (r_state == ST_DATA) || (r_state == ST_FIN);

endmodule
